uart_rom_loader: RTL and testbench
==================================

Name: uart_rom_loader

Overview:
- Receives a CHIP-8 program image over the board UART and writes it byte-by-byte into external RAM through the memory controller's write port.
- On a verified image it pulses start to the core. It sits upstream of the memory controller and core, in the slot the soft-processor load path occupies today.
- While a session is active it owns the memory write port: loading=1 selects the loader's mem_* outputs in the top-level mux.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).
- LOAD_BASE, 26'h000200, memory address of image byte 0.
- MAX_LEN, 3584, largest accepted image length in bytes.
- TIMEOUT_CLKS, 10_000_000, idle clocks allowed between bytes inside a session before abort.

Ports:
- clk_100mhz  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  UART receive line, idle high, asynchronous
- mem_busy  in  1  memory controller busy
- mem_write  out  1  one-cycle write request
- mem_address  out  26  write address
- mem_write_data  out  16  {8'd0, byte}
- loading  out  1  session active; owns memory port
- start  out  1  one-cycle pulse after a good load
- done  out  1  sticky; last session succeeded
- error  out  2  sticky code: 0 none, 1 checksum, 2 length, 3 framing/timeout
- byte_count  out  12  bytes written in current/last session

Behaviour:
- Reset is synchronous and active-high on clk_100mhz; single clock domain.
- Reset values: all outputs 0. FSM returns to IDLE and the UART receiver to line-idle. Reset mid-session abandons the write in progress, leaves no request pending, and does not pulse start.
- UART RX:
  - rx passes through a 2-FF synchronizer.
  - A falling edge while idle starts a frame. Sample at CLKS_PER_BIT/2; if the line is high, treat it as a glitch and return to idle.
  - Then 8 data bits LSB first, each sampled CLKS_PER_BIT later, then the stop bit.
  - Stop=1: raise internal rx_valid for 1 cycle with the byte.
  - Stop=0: framing error. Inside a session this aborts with error=3. In IDLE the byte is silently dropped.
- Protocol: 0x55 sync, LEN_HI, LEN_LO (big-endian), LEN data bytes, then CSUM = 8-bit sum of data bytes mod 256.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WR_REQ, WR_WAIT_HI, WR_WAIT_LO, CSUM.
- IDLE:
  - Non-0x55 bytes are ignored.
  - 0x55 moves to LEN_HI, sets loading=1, and clears done, error, byte_count and the running sum.
- LEN_LO → error path: length > MAX_LEN sets error=2, loading=0, returns to IDLE.
- LEN_LO → CSUM: length==0 goes directly to CSUM.
- LEN_LO → DATA: all other lengths.
- DATA: a received byte is latched into a 1-byte holding register, added to the sum, then the FSM moves to WR_REQ.
- WR_REQ:
  - Waits for mem_busy==0.
  - Then drives mem_write=1 for exactly one cycle with mem_address = LOAD_BASE + byte_count and mem_write_data = {8'd0, byte}.
  - Address and data stay stable until WR_WAIT_LO exits.
- WR_WAIT_HI / WR_WAIT_LO: wait for mem_busy=1, then for mem_busy=0.
- After each write: byte_count increments. If byte_count==LEN go to CSUM, else return to DATA.
- Overrun: a byte arriving while not in DATA/CSUM (write still pending) aborts with error=3.
- CSUM:
  - Match: done=1, start=1 for exactly one cycle, loading=0, then IDLE.
  - Mismatch: error=1, loading=0, no start, then IDLE.
- Timeout: an inter-byte counter resets on every rx_valid. Reaching TIMEOUT_CLKS in any non-IDLE state aborts with error=3 and loading=0.
  - A timeout during WR_WAIT_* aborts immediately, without waiting for busy to drop.
- done and error persist until the next 0x55 sync or reset.
- Arithmetic widths: LEN is 16 bits and compared before any truncation to 12 bits; the address sum is 26-bit unsigned; the checksum wraps at 8 bits.

Test Plan:
- Good load: send 55 00 03 A0 B1 C2 13 with a memory model that holds busy 4 cycles after each write. Required: 3 writes to 0x200/0x201/0x202 with data 0x00A0/0x00B1/0x00C2, byte_count=3, done=1, one start pulse, error=0, loading falls.
- Checksum fail: send 55 00 02 01 02 04. Required: 2 writes occur, error=1, done=0, no start.
- Length limit and zero length: send 55 0E 01. Required: error=2 with no writes. Then send 55 00 00 00. Required: done=1, start pulses, byte_count=0.
- Framing and glitch:
  - Mid-session data byte with stop bit 0 → error=3, loading=0.
  - A 100-cycle low glitch on rx in IDLE → no byte received, no state change.
- Busy stall and timeout:
  - Hold mem_busy=1 for 5000 cycles before the first write → mem_write is not asserted until busy=0, and the write then completes.
  - With TIMEOUT_CLKS=2000, send 55 00 05 01 then stop → error=3 and loading=0, 2000 cycles after the last byte.
- Reset mid-session: assert rst for 1 cycle in WR_WAIT_LO. Required: next-cycle outputs all 0, FSM in IDLE, and a subsequent good load succeeds.

Source files
------------

// File: rtl/uart_rom_loader.sv
// UART program loader: receives a length-prefixed, checksummed CHIP-8 image over
// the serial line and writes it byte-by-byte into external RAM, then starts the core.
module uart_rom_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [25:0] LOAD_BASE    = 26'h000200,
    parameter int unsigned MAX_LEN      = 3584,
    parameter int unsigned TIMEOUT_CLKS = 10_000_000
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic        rx,
    input  logic        mem_busy,
    output logic        mem_write,
    output logic [25:0] mem_address,
    output logic [15:0] mem_write_data,
    output logic        loading,
    output logic        start,
    output logic        done,
    output logic [1:0]  error,
    output logic [11:0] byte_count
);
    localparam int unsigned BitCntW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned ToCntW  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BitCntW-1:0] HalfBit = BitCntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BitCntW-1:0] FullBit = BitCntW'(CLKS_PER_BIT - 1);
    localparam logic [ToCntW-1:0]  ToLast  = ToCntW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StWrReq, StWrWaitHi, StWrWaitLo, StCsum
    } state_e;

    // UART receiver
    rx_state_e          rx_state_q, rx_state_d;
    logic               rx_meta_q, rx_sync_q, rx_prev_q;
    logic [BitCntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic               rx_valid, rx_ferr;

    // Loader
    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d, len_full;
    logic [7:0]        sum_q, sum_d, hold_q, hold_d;
    logic [11:0]       count_q, count_d;
    logic [ToCntW-1:0] to_cnt_q, to_cnt_d;
    logic              done_q, done_d, start_q, start_d;
    logic [1:0]        error_q, error_d;
    logic              in_write, timeout_hit, abort;

    // rx synchronizer, edge history and receiver state
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Receiver next state: mid-bit sampling, glitch rejection, stop-bit check
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == HalfBit) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // Line back high at mid start bit: a glitch, not a frame
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == FullBit) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == FullBit) begin
                    rx_state_d = RxIdle;
                    rx_valid   = rx_sync_q;
                    rx_ferr    = !rx_sync_q;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    assign len_full    = {len_q[15:8], rx_shift_q};
    assign in_write    = state_q inside {StWrReq, StWrWaitHi, StWrWaitLo};
    assign timeout_hit = (state_q != StIdle) && !rx_valid && (to_cnt_q == ToLast);
    // Framing error, timeout or a byte arriving while a write is pending ends the session
    assign abort = (state_q != StIdle) && (timeout_hit || rx_ferr || (rx_valid && in_write));

    // Loader state register and session datapath
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q  <= StIdle;
            len_q    <= '0;
            sum_q    <= '0;
            hold_q   <= '0;
            count_q  <= '0;
            to_cnt_q <= '0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            error_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            sum_q    <= sum_d;
            hold_q   <= hold_d;
            count_q  <= count_d;
            to_cnt_q <= to_cnt_d;
            done_q   <= done_d;
            start_q  <= start_d;
            error_q  <= error_d;
        end
    end

    // Loader next state: protocol parsing, write sequencing, status codes
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        sum_d    = sum_q;
        hold_d   = hold_q;
        count_d  = count_q;
        done_d   = done_q;
        error_d  = error_q;
        start_d  = 1'b0;
        to_cnt_d = (state_q == StIdle || rx_valid) ? '0 : to_cnt_q + 1'b1;
        if (abort) begin
            state_d = StIdle;
            error_d = 2'd3;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_valid && rx_shift_q == 8'h55) begin
                        state_d = StLenHi;
                        done_d  = 1'b0;
                        error_d = 2'd0;
                        count_d = '0;
                        sum_d   = '0;
                    end
                end
                StLenHi: begin
                    if (rx_valid) begin
                        len_d   = {rx_shift_q, 8'h00};
                        state_d = StLenLo;
                    end
                end
                StLenLo: begin
                    if (rx_valid) begin
                        len_d = len_full;
                        if ({16'd0, len_full} > MAX_LEN) begin
                            error_d = 2'd2;
                            state_d = StIdle;
                        end else if (len_full == 16'd0) begin
                            state_d = StCsum;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (rx_valid) begin
                        hold_d  = rx_shift_q;
                        sum_d   = sum_q + rx_shift_q;
                        state_d = StWrReq;
                    end
                end
                StWrReq:    if (!mem_busy) state_d = StWrWaitHi;
                StWrWaitHi: if (mem_busy) state_d = StWrWaitLo;
                StWrWaitLo: begin
                    if (!mem_busy) begin
                        count_d = count_q + 12'd1;
                        state_d = ({4'd0, count_q} + 16'd1 == len_q) ? StCsum : StData;
                    end
                end
                StCsum: begin
                    if (rx_valid) begin
                        state_d = StIdle;
                        if (rx_shift_q == sum_q) begin
                            done_d  = 1'b1;
                            start_d = 1'b1;
                        end else begin
                            error_d = 2'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs: memory port driven only while a write is in flight
    always_comb begin
        mem_write      = (state_q == StWrReq) && !mem_busy && !abort;
        mem_address    = in_write ? LOAD_BASE + {14'd0, count_q} : 26'd0;
        mem_write_data = in_write ? {8'd0, hold_q} : 16'd0;
        loading        = (state_q != StIdle);
        start          = start_q;
        done           = done_q;
        error          = error_q;
        byte_count     = count_q;
    end
endmodule

// File: tb/tb_uart_rom_loader.sv
// Self-checking bench for uart_rom_loader: UART byte driver, busy-holding memory model,
// write scoreboard and one task per scenario.
module tb_uart_rom_loader;
    localparam int CPB = 32;
    localparam int TO  = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        force_busy = 1'b0;
    logic        mem_busy;
    logic        mem_write;
    logic [25:0] mem_address;
    logic [15:0] mem_write_data;
    logic        loading, start, done;
    logic [1:0]  error;
    logic [11:0] byte_count;

    int n_vec = 0;
    int n_err = 0;
    int busy_cnt = 0;
    int start_cyc = 0;
    int rd_idx = 0;
    logic [41:0] exp_q[$];
    logic [41:0] obs_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    // Memory model: busy for 4 cycles after each write request
    always @(posedge clk) begin
        if (mem_write) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign mem_busy = force_busy || (busy_cnt != 0);

    // Monitor: record every write-request cycle and every start-high cycle
    always @(negedge clk) begin
        if (mem_write) obs_q.push_back({mem_address, mem_write_data});
        if (start) start_cyc++;
    end

    uart_rom_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk_100mhz(clk), .rst(rst), .rx(rx), .mem_busy(mem_busy),
        .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .loading(loading), .start(start), .done(done), .error(error),
        .byte_count(byte_count)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic send_all();
        while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (loading === 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (loading !== 1'b0) begin
            n_err++;
            $display("FAIL %s: loading=%b after %0d cycles, required 0", name, loading, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({mem_write, mem_address, mem_write_data, loading, start, done, error, byte_count}
            !== 60'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {mem_write, mem_address, mem_write_data, loading, start, done, error,
                      byte_count});
        end
    endtask

    task automatic test_good_load();
        logic [41:0] e, g;
        int s0;
        s0 = start_cyc;
        exp_q.push_back({26'h200, 16'h00A0});
        exp_q.push_back({26'h201, 16'h00B1});
        exp_q.push_back({26'h202, 16'h00C2});
        tx_q = '{8'h55};
        send_all();
        @(negedge clk);
        n_vec++;
        if (loading !== 1'b1) begin
            n_err++;
            $display("FAIL good_loading: loading=%b, required 1", loading);
        end
        tx_q = '{8'h00, 8'h03, 8'hA0, 8'hB1, 8'hC2, 8'h13};
        send_all();
        wait_idle("good_idle");
        n_vec++;
        if (obs_q.size() - rd_idx != exp_q.size()) begin
            n_err++;
            $display("FAIL good_nwrites: %0d, required %0d", obs_q.size() - rd_idx, exp_q.size());
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : '1;
            rd_idx++;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL good_write: addr_data=%h, required %h", g, e);
            end
        end
        rd_idx = obs_q.size();
        n_vec++;
        if ({byte_count, done, error} !== {12'd3, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL good_status: count=%0d done=%b error=%0d, required 3/1/0",
                     byte_count, done, error);
        end
        n_vec++;
        if (start_cyc - s0 != 1) begin
            n_err++;
            $display("FAIL good_start: %0d start cycles, required 1", start_cyc - s0);
        end
    endtask

    task automatic test_csum_fail();
        logic [41:0] e, g;
        int s0;
        s0 = start_cyc;
        exp_q.push_back({26'h200, 16'h0001});
        exp_q.push_back({26'h201, 16'h0002});
        tx_q = '{8'h55, 8'h00, 8'h02, 8'h01, 8'h02, 8'h04};
        send_all();
        wait_idle("csum_idle");
        n_vec++;
        if (obs_q.size() - rd_idx != exp_q.size()) begin
            n_err++;
            $display("FAIL csum_nwrites: %0d, required %0d", obs_q.size() - rd_idx, exp_q.size());
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : '1;
            rd_idx++;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL csum_write: addr_data=%h, required %h", g, e);
            end
        end
        rd_idx = obs_q.size();
        n_vec++;
        if ({error, done} !== {2'd1, 1'b0} || start_cyc != s0) begin
            n_err++;
            $display("FAIL csum_status: error=%0d done=%b starts=%0d, required 1/0/0",
                     error, done, start_cyc - s0);
        end
    endtask

    task automatic test_len_limit_zero();
        int s0;
        tx_q = '{8'h55, 8'h0E, 8'h01};
        send_all();
        wait_idle("len_idle");
        n_vec++;
        if (error !== 2'd2 || obs_q.size() != rd_idx) begin
            n_err++;
            $display("FAIL len_limit: error=%0d writes=%0d, required 2/0",
                     error, obs_q.size() - rd_idx);
        end
        s0 = start_cyc;
        tx_q = '{8'h55, 8'h00, 8'h00, 8'h00};
        send_all();
        wait_idle("zero_idle");
        n_vec++;
        if ({done, error, byte_count} !== {1'b1, 2'd0, 12'd0} || obs_q.size() != rd_idx) begin
            n_err++;
            $display("FAIL zero_len: done=%b error=%0d count=%0d writes=%0d, required 1/0/0/0",
                     done, error, byte_count, obs_q.size() - rd_idx);
        end
        n_vec++;
        if (start_cyc - s0 != 1) begin
            n_err++;
            $display("FAIL zero_start: %0d start cycles, required 1", start_cyc - s0);
        end
    endtask

    task automatic test_framing_glitch();
        logic [41:0] g;
        tx_q = '{8'h55, 8'h00, 8'h02};
        send_all();
        send_byte(8'h11, 1'b0);
        wait_idle("frame_idle");
        n_vec++;
        if (error !== 2'd3 || obs_q.size() != rd_idx) begin
            n_err++;
            $display("FAIL framing: error=%0d writes=%0d, required 3/0",
                     error, obs_q.size() - rd_idx);
        end
        // Short low pulse in idle must not start a frame
        tick(2 * CPB);
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(2 * CPB);
        @(negedge clk);
        n_vec++;
        if ({loading, error} !== {1'b0, 2'd3}) begin
            n_err++;
            $display("FAIL glitch_state: loading=%b error=%0d, required 0/3", loading, error);
        end
        tx_q = '{8'h55, 8'h00, 8'h01, 8'h3C, 8'h3C};
        send_all();
        wait_idle("glitch_load_idle");
        g = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : '1;
        n_vec++;
        if (g !== {26'h200, 16'h003C} || obs_q.size() != rd_idx + 1 || done !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_load: write=%h n=%0d done=%b, required %h/1/1",
                     g, obs_q.size() - rd_idx, done, {26'h200, 16'h003C});
        end
        rd_idx = obs_q.size();
    endtask

    task automatic test_busy_stall();
        logic [41:0] g;
        force_busy = 1'b1;
        tx_q = '{8'h55, 8'h00, 8'h01, 8'h7E};
        send_all();
        tick(1200);
        n_vec++;
        if (obs_q.size() != rd_idx) begin
            n_err++;
            $display("FAIL stall_nowrite: %0d writes while busy, required 0", obs_q.size() - rd_idx);
        end
        force_busy = 1'b0;
        tick(20);
        g = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : '1;
        n_vec++;
        if (g !== {26'h200, 16'h007E} || obs_q.size() != rd_idx + 1) begin
            n_err++;
            $display("FAIL stall_write: write=%h n=%0d, required %h/1",
                     g, obs_q.size() - rd_idx, {26'h200, 16'h007E});
        end
        rd_idx = obs_q.size();
        tx_q = '{8'h7E};
        send_all();
        wait_idle("stall_idle");
        n_vec++;
        if ({done, error, byte_count} !== {1'b1, 2'd0, 12'd1}) begin
            n_err++;
            $display("FAIL stall_status: done=%b error=%0d count=%0d, required 1/0/1",
                     done, error, byte_count);
        end
    endtask

    task automatic test_timeout();
        tx_q = '{8'h55, 8'h00, 8'h05, 8'h01};
        send_all();
        tick(1900);
        @(negedge clk);
        n_vec++;
        if ({loading, error} !== {1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL timeout_early: loading=%b error=%0d, required 1/0", loading, error);
        end
        tick(150);
        @(negedge clk);
        n_vec++;
        if ({loading, error, byte_count} !== {1'b0, 2'd3, 12'd1}) begin
            n_err++;
            $display("FAIL timeout_abort: loading=%b error=%0d count=%0d, required 0/3/1",
                     loading, error, byte_count);
        end
        rd_idx = obs_q.size();
    endtask

    task automatic test_reset_mid();
        logic [41:0] g;
        int s0, k;
        s0 = start_cyc;
        tx_q = '{8'h55, 8'h00, 8'h02};
        send_all();
        rx = 1'b0;
        fork
            send_byte(8'h11, 1'b1);
        join_none
        k = 0;
        @(negedge clk);
        while (mem_write !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_write: no write within %0d cycles, required one", k);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (mem_address !== 26'h200) begin
            n_err++;
            $display("FAIL rstmid_pre: mem_address=%h, required 200", mem_address);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({mem_write, mem_address, mem_write_data, loading, start, done, error, byte_count}
            !== 60'd0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got %h, required 0",
                     {mem_write, mem_address, mem_write_data, loading, start, done, error,
                      byte_count});
        end
        wait fork;
        tick(2 * CPB);
        n_vec++;
        if (start_cyc != s0 || loading !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_quiet: starts=%0d loading=%b, required 0/0",
                     start_cyc - s0, loading);
        end
        rd_idx = obs_q.size();
        tx_q = '{8'h55, 8'h00, 8'h01, 8'h5A, 8'h5A};
        send_all();
        wait_idle("rstmid_idle");
        g = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : '1;
        n_vec++;
        if (g !== {26'h200, 16'h005A} || obs_q.size() != rd_idx + 1) begin
            n_err++;
            $display("FAIL rstmid_reload_write: write=%h n=%0d, required %h/1",
                     g, obs_q.size() - rd_idx, {26'h200, 16'h005A});
        end
        n_vec++;
        if ({done, error, byte_count} !== {1'b1, 2'd0, 12'd1} || start_cyc - s0 != 1) begin
            n_err++;
            $display("FAIL rstmid_reload: done=%b error=%0d count=%0d starts=%0d, required 1/0/1/1",
                     done, error, byte_count, start_cyc - s0);
        end
        rd_idx = obs_q.size();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_load();
        test_csum_fail();
        test_len_limit_zero();
        test_framing_glitch();
        test_busy_stall();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
